// File: rtl/uart_pkg.sv
// Shared types and register map constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [31:0] UART_TXDATA_OFF = 32'd0;
    localparam logic [31:0] UART_STATUS_OFF = 32'd4;

    localparam int STAT_FULL = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && push) begin
            assert ((DEPTH & (DEPTH - 1)) == 0)
                else $error("sync_fifo: DEPTH=%0d is not a power of two", DEPTH);
        end
    end
`endif

endmodule

// File: rtl/uart_tx_mmio.sv
// Store-driven 8N1 UART transmitter: TX data register feeds a FIFO, status register reports full/busy/overflow.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy,
    output logic        fifo_full
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BCNT_LAST   = 16'(CLK_DIV - 1);
    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + UART_TXDATA_OFF;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + UART_STATUS_OFF;

    tx_state_t      state;
    tx_state_t      state_next;
    logic [15:0]    bcnt;
    logic [15:0]    bcnt_next;
    logic [2:0]     bit_idx;
    logic [2:0]     bit_idx_next;
    logic [7:0]     shift;
    logic [7:0]     shift_next;
    logic           tx_next;
    logic           bit_done;
    logic           pop;
    logic           ovf;
    logic           data_wr;
    logic           stat_wr;
    logic           stat_rd;
    logic [7:0]     head;
    logic           empty;
    logic [CW-1:0]  count;
    logic [31:0]    status;
    logic           unused;

    assign data_wr = mem_write && (addr == TXDATA_ADDR);
    assign stat_wr = mem_write && (addr == STATUS_ADDR);
    assign stat_rd = mem_read  && (addr == STATUS_ADDR);
    assign unused  = &{1'b0, wdata[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (empty),
        .count (count)
    );

    assign tx_busy  = (state != IDLE) || (count != '0);
    assign bit_done = (bcnt == BCNT_LAST);

    // tx_next is the line level for the cycle after this edge, so tx stays a plain register.
    always_comb begin
        state_next   = state;
        bcnt_next    = bcnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = tx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    bcnt_next  = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    bcnt_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                    tx_next      = shift[0];
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bcnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shift[1];
                    end
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    bcnt_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcnt    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            state   <= state_next;
            bcnt    <= bcnt_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
            if (data_wr && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (stat_wr && wdata[STAT_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    always_comb begin
        status            = '0;
        status[STAT_FULL] = fifo_full;
        status[STAT_BUSY] = tx_busy;
        status[STAT_OVF]  = ovf;
        rdata             = stat_rd ? status : 32'h0;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a serial monitor decodes frames and compares against queued bytes.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;
    logic        fifo_full;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          frames   = 0;
    bit          mon_busy = 1'b0;
    logic [7:0]  sb[$];
    int          starts[$];

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drives at posedge+1; returns at posedge+1 of the edge that registered the store.
    task automatic store(input logic [31:0] a, input logic [31:0] d, output int en);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        @(posedge clk); #1;
        en        = cyc;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        mem_read = 1'b1;
        addr     = BASE + 32'd4;
        #1;
        chk(tag, rdata, exp);
        mem_read = 1'b0;
        addr     = '0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_busy || mon_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    // Serial monitor: samples mid-bit on the falling clock edge, aborts a frame on reset.
    initial begin : monitor
        int         st;
        logic [7:0] b;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            st       = cyc;
            b        = '0;
            aborted  = 1'b0;
            mon_busy = 1'b1;
            starts.push_back(st);
            for (int i = 1; i < FRAME; i++) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (i == DIV / 2)
                    chk("start_bit", 32'(tx), 32'd0);
                else if (i >= DIV && i < 9 * DIV && (i % DIV) == DIV / 2)
                    b[(i / DIV) - 1] = tx;
                else if (i == 9 * DIV + DIV / 2)
                    chk("stop_bit", 32'(tx), 32'd1);
            end
            if (!aborted) begin
                frames++;
                if (sb.size() == 0)
                    chk("frame_expected", 32'(sb.size()), 32'd1);
                else
                    chk("frame_byte", 32'(b), 32'(sb.pop_front()));
            end
            mon_busy = 1'b0;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, n0, s0, f, bad;
        rst       = 1'b1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        addr      = '0;
        wdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Idle for 100 cycles
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("idle_line", 32'(bad), 32'd0);
        rd_status("idle_status", 32'h0);

        // Single byte 0x55: exact start latency and busy window
        sb.push_back(8'h55);
        store(BASE, 32'h55, n);
        chk("pre_start_tx", 32'(tx), 32'd1);
        chk("busy_on_store", 32'(tx_busy), 32'd1);
        wait_until(n + 1);
        chk("start_low", 32'(tx), 32'd0);
        wait_until(n + 40);
        chk("busy_last_cycle", 32'(tx_busy), 32'd1);
        wait_until(n + 41);
        chk("busy_dropped", 32'(tx_busy), 32'd0);
        chk("idle_after_frame", 32'(tx), 32'd1);
        wait_drain("drain_55", 100);
        chk("start_time_55", 32'(starts[starts.size() - 1]), 32'(n + 1));

        // Three back-to-back bytes, contiguous frames
        s0 = starts.size();
        sb.push_back(8'h41);
        sb.push_back(8'h42);
        sb.push_back(8'h43);
        store(BASE, 32'h41, n0);
        store(BASE, 32'h42, n);
        store(BASE, 32'h43, n);
        wait_drain("drain_abc", 300);
        chk("abc_frames", 32'(starts.size() - s0), 32'd3);
        chk("abc_first_start", 32'(starts[s0]), 32'(n0 + 1));
        chk("abc_gap1", 32'(starts[s0 + 1] - starts[s0]), 32'(FRAME));
        chk("abc_gap2", 32'(starts[s0 + 2] - starts[s0 + 1]), 32'(FRAME));

        // Overflow: six stores into a depth-4 FIFO, sixth is dropped
        s0 = starts.size();
        for (int k = 0; k < 5; k++) sb.push_back(8'(8'h10 + k));
        store(BASE, 32'h10, n0);
        for (int k = 1; k < 6; k++) store(BASE, 32'(8'h10 + k), n);
        chk("ovf_full_flag", 32'(fifo_full), 32'd1);
        rd_status("status_ovf_busy_full", 32'h7);
        wait_until(n0 + 40);
        rd_status("status_before_pop", 32'h7);
        wait_until(n0 + 41);
        rd_status("status_after_pop", 32'h6);
        store(BASE + 32'd4, 32'h4, n);
        rd_status("status_ovf_cleared", 32'h2);
        wait_drain("drain_fill", 600);
        f = frames;
        repeat (60) begin
            @(posedge clk); #1;
        end
        chk("no_dropped_frame", 32'(frames), 32'(f));
        chk("fill_frames", 32'(starts.size() - s0), 32'd5);
        chk("fill_contiguous", 32'(starts[s0 + 4] - starts[s0]), 32'(4 * FRAME));

        // Reset in the middle of DATA bit 3 abandons the frame and flushes the FIFO
        sb.push_back(8'hA5);
        store(BASE, 32'hA5, n);
        store(BASE, 32'h77, n0);
        wait_until(n + 18);
        chk("bit3_level", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);
        chk("rst_mid_full", 32'(fifo_full), 32'd0);
        rd_status("rst_mid_status", 32'h0);
        f = frames;
        s0 = starts.size();
        sb.push_back(8'h3C);
        store(BASE, 32'h3C, n);
        wait_drain("drain_after_rst", 200);
        repeat (60) begin
            @(posedge clk); #1;
        end
        chk("post_rst_frames", 32'(frames), 32'(f + 1));
        chk("post_rst_start", 32'(starts[s0]), 32'(n + 1));

        // Unmapped store and data-register read
        f = frames;
        store(BASE + 32'd8, 32'h99, n);
        chk("unmapped_busy", 32'(tx_busy), 32'd0);
        chk("unmapped_full", 32'(fifo_full), 32'd0);
        mem_read = 1'b1;
        addr     = BASE;
        #1;
        chk("read_txdata_zero", rdata, 32'h0);
        addr = BASE + 32'd8;
        #1;
        chk("read_unmapped_zero", rdata, 32'h0);
        mem_read = 1'b0;
        addr     = BASE + 32'd4;
        #1;
        chk("status_no_read_zero", rdata, 32'h0);
        addr = '0;
        bad  = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) bad++;
        end
        chk("unmapped_tx_idle", 32'(bad), 32'd0);
        chk("unmapped_no_frame", 32'(frames), 32'(f));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
